// File: rtl/scr1_timer_seq.sv
// Timer compare sequencer: drives the glitch-free HI/LO/HI mtimecmp update over the timer dmem port.
// Optional miss counter output enabled by defining SCR1_TIMER_SEQ_MISS_CNT_EN.

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

package scr1_timer_seq_pkg;
    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    localparam logic       SCR1_MEM_CMD_RD        = 1'b0;
    localparam logic       SCR1_MEM_CMD_WR        = 1'b1;
    localparam logic [1:0] SCR1_MEM_RESP_NOTRDY   = 2'b00;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_OK   = 2'b01;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_ER   = 2'b10;

    localparam logic [1:0] OP_ABS      = 2'b00;
    localparam logic [1:0] OP_REL      = 2'b01;
    localparam logic [1:0] OP_STOP     = 2'b10;
    localparam logic [1:0] OP_PERIODIC = 2'b11;
endpackage

module scr1_timer_seq
    import scr1_timer_seq_pkg::*;
#(
    parameter logic [31:0] TMR_BASE     = 32'hF004_0000,
    parameter int unsigned RESP_TIMEOUT = 15
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [63:0]                      cmd_data,
    input  logic [63:0]                      timer_val,
    input  logic                             timer_irq,
    output logic                             tmr_req,
    output logic                             tmr_cmd,
    output type_scr1_mem_width_e             tmr_width,
    output logic [`SCR1_DMEM_AWIDTH-1:0]     tmr_addr,
    output logic [`SCR1_DMEM_DWIDTH-1:0]     tmr_wdata,
    input  logic                             tmr_req_ack,
    input  logic [1:0]                       tmr_resp,
    output logic                             busy,
    output logic                             err,
    output logic                             periodic,
    output logic [31:0]                      tick_cnt
`ifdef SCR1_TIMER_SEQ_MISS_CNT_EN
   ,output logic [15:0]                      miss_cnt
`endif
);

    // state  | meaning
    // IDLE   | waiting for a command or a periodic reload
    // ISSUE  | tmr_req asserted for the current step until acked
    // WAIT   | waiting for the slave response of the current step
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam int AW = `SCR1_DMEM_AWIDTH;
    localparam int DW = `SCR1_DMEM_DWIDTH;
    localparam logic [AW-1:0] ADDR_LO  = AW'(TMR_BASE + 32'h10);
    localparam logic [AW-1:0] ADDR_HI  = AW'(TMR_BASE + 32'h14);
    localparam logic [7:0]    TMO_LAST = 8'(RESP_TIMEOUT - 1);

    state_e      state, state_nxt;
    logic [1:0]  step;
    logic [63:0] cmp_shadow;
    logic [63:0] period;
    logic [7:0]  tmo_cnt;
    logic        is_reload;

    logic        reload_cond;
    logic        accept;
    logic        start_reload;
    logic        start_cmd;
    logic        step_inc;
    logic        seq_done;
    logic        seq_fail;
    logic        resp_bad;
    logic [63:0] target;
    logic [63:0] reload_cmp;

    assign reload_cond = periodic & timer_irq;
    assign cmd_ready   = (state == ST_IDLE) & ~reload_cond;
    assign busy        = (state != ST_IDLE) | reload_cond;
    assign accept      = cmd_valid & cmd_ready;
    assign target      = (cmd_op == OP_ABS) ? cmd_data : timer_val + cmd_data;
    assign reload_cmp  = cmp_shadow + period;
    // Any response that is neither NOTRDY nor OK is treated as a slave error.
    assign resp_bad    = (tmr_resp != SCR1_MEM_RESP_RDY_OK) & (tmr_resp != SCR1_MEM_RESP_NOTRDY);

    always_comb begin
        state_nxt    = state;
        start_reload = 1'b0;
        start_cmd    = 1'b0;
        step_inc     = 1'b0;
        seq_done     = 1'b0;
        seq_fail     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (reload_cond) begin
                    start_reload = 1'b1;
                    state_nxt    = ST_ISSUE;
                end else if (accept && (cmd_op != OP_STOP)) begin
                    start_cmd = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (tmr_req_ack) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (tmr_resp == SCR1_MEM_RESP_RDY_OK) begin
                    if (step == 2'd2) begin
                        seq_done  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        step_inc  = 1'b1;
                        state_nxt = ST_ISSUE;
                    end
                end else if (resp_bad || (tmo_cnt == TMO_LAST)) begin
                    seq_fail  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        tmr_req   = (state == ST_ISSUE);
        tmr_cmd   = tmr_req ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
        tmr_width = SCR1_MEM_WIDTH_WORD;
        tmr_addr  = '0;
        tmr_wdata = '0;
        if (tmr_req) begin
            case (step)
                2'd0: begin
                    tmr_addr  = ADDR_HI;
                    tmr_wdata = DW'(32'hFFFF_FFFF);
                end
                2'd1: begin
                    tmr_addr  = ADDR_LO;
                    tmr_wdata = DW'(cmp_shadow[31:0]);
                end
                default: begin
                    tmr_addr  = ADDR_HI;
                    tmr_wdata = DW'(cmp_shadow[63:32]);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            step       <= 2'd0;
            cmp_shadow <= '0;
            period     <= '0;
            tmo_cnt    <= '0;
            is_reload  <= 1'b0;
            err        <= 1'b0;
            periodic   <= 1'b0;
            tick_cnt   <= '0;
`ifdef SCR1_TIMER_SEQ_MISS_CNT_EN
            miss_cnt   <= '0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) err <= 1'b0;

            if (start_reload) begin
                cmp_shadow <= reload_cmp;
                step       <= 2'd0;
                is_reload  <= 1'b1;
`ifdef SCR1_TIMER_SEQ_MISS_CNT_EN
                if ((reload_cmp <= timer_val) && (miss_cnt != 16'hFFFF))
                    miss_cnt <= miss_cnt + 16'd1;
`endif
            end else if (start_cmd) begin
                cmp_shadow <= target;
                step       <= 2'd0;
                is_reload  <= 1'b0;
                if (cmd_op == OP_PERIODIC) begin
                    period   <= cmd_data;
                    periodic <= 1'b1;
                    tick_cnt <= '0;
`ifdef SCR1_TIMER_SEQ_MISS_CNT_EN
                    miss_cnt <= '0;
`endif
                end
            end else if (accept && (cmd_op == OP_STOP)) begin
                periodic <= 1'b0;
            end

            if ((state == ST_ISSUE) && tmr_req_ack) tmo_cnt <= '0;
            else if (state == ST_WAIT)              tmo_cnt <= tmo_cnt + 8'd1;

            if (step_inc) step <= step + 2'd1;
            if (seq_done && is_reload) tick_cnt <= tick_cnt + 32'd1;
            if (seq_fail) begin
                err      <= 1'b1;
                periodic <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_scr1_timer_seq.sv
// Scoreboard bench for scr1_timer_seq: expected bus writes are queued by the stimulus and
// checked by a monitor; a small timer slave model generates acks, responses and timer_irq.
`timescale 1ns/1ps

`ifndef SCR1_DMEM_AWIDTH
`define SCR1_DMEM_AWIDTH 32
`endif
`ifndef SCR1_DMEM_DWIDTH
`define SCR1_DMEM_DWIDTH 32
`endif

module tb_scr1_timer_seq;
    import scr1_timer_seq_pkg::*;

    localparam logic [31:0] A_LO = 32'hF004_0010;
    localparam logic [31:0] A_HI = 32'hF004_0014;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [63:0] cmd_data;
    logic [63:0] timer_val;
    logic        timer_irq;
    logic        tmr_req;
    logic        tmr_cmd;
    type_scr1_mem_width_e tmr_width;
    logic [`SCR1_DMEM_AWIDTH-1:0] tmr_addr;
    logic [`SCR1_DMEM_DWIDTH-1:0] tmr_wdata;
    logic        tmr_req_ack;
    logic [1:0]  tmr_resp = 2'b00;
    logic        busy;
    logic        err;
    logic        periodic;
    logic [31:0] tick_cnt;
`ifdef SCR1_TIMER_SEQ_MISS_CNT_EN
    logic [15:0] miss_cnt;
`endif

    scr1_timer_seq #(.TMR_BASE(32'hF004_0000), .RESP_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .timer_val(timer_val), .timer_irq(timer_irq),
        .tmr_req(tmr_req), .tmr_cmd(tmr_cmd), .tmr_width(tmr_width), .tmr_addr(tmr_addr),
        .tmr_wdata(tmr_wdata), .tmr_req_ack(tmr_req_ack), .tmr_resp(tmr_resp),
        .busy(busy), .err(err), .periodic(periodic), .tick_cnt(tick_cnt)
`ifdef SCR1_TIMER_SEQ_MISS_CNT_EN
       ,.miss_cnt(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Timer slave model: immediate ack, registered response, real compare registers.
    logic [31:0] cmp_lo = 32'hFFFF_FFFF;
    logic [31:0] cmp_hi = 32'hFFFF_FFFF;
    int          wr_num = 0;
    int          er_at  = -1;
    bit          no_resp = 1'b0;
    bit          ack_en  = 1'b1;

    assign tmr_req_ack = tmr_req & ack_en;
    assign timer_irq   = (timer_val >= {cmp_hi, cmp_lo});

    always @(posedge clk) begin
        if (tmr_req && tmr_req_ack) begin
            wr_num <= wr_num + 1;
            if (tmr_addr == A_LO)      cmp_lo <= tmr_wdata;
            else if (tmr_addr == A_HI) cmp_hi <= tmr_wdata;
            if (no_resp)                  tmr_resp <= SCR1_MEM_RESP_NOTRDY;
            else if (wr_num + 1 == er_at) tmr_resp <= SCR1_MEM_RESP_RDY_ER;
            else                          tmr_resp <= SCR1_MEM_RESP_RDY_OK;
        end else begin
            tmr_resp <= SCR1_MEM_RESP_NOTRDY;
        end
    end

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  errors = 0;
    int  checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_seq(input logic [63:0] cmp);
        exp_q.push_back('{addr: A_HI, data: 32'hFFFF_FFFF});
        exp_q.push_back('{addr: A_LO, data: cmp[31:0]});
        exp_q.push_back('{addr: A_HI, data: cmp[63:32]});
    endtask

    always @(negedge clk) begin
        if (rst_n && tmr_req && tmr_req_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", tmr_addr, tmr_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("bus_addr", tmr_addr, mon_e.addr);
                check("bus_data", tmr_wdata, mon_e.data);
                check("bus_cmd", tmr_cmd, SCR1_MEM_CMD_WR);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic [1:0] op, input logic [63:0] data);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        #1;
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: got cmd_ready=0 expected 1 within 300 cycles");
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        #1;
        while (!(cmd_ready && !busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!(cmd_ready && !busy)) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: got busy=%0b expected idle within 500 cycles", busy);
        end
    endtask

    initial begin
        int n;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = '0;
        timer_val = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_tmr_req", tmr_req, 0);
        check("rst_tmr_addr", tmr_addr, 0);
        check("rst_tmr_wdata", tmr_wdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_periodic", periodic, 0);
        check("rst_tick_cnt", tick_cnt, 0);
`ifdef SCR1_TIMER_SEQ_MISS_CNT_EN
        check("rst_miss_cnt", miss_cnt, 0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // ABS with latency measurement
        push_seq(64'h0000_0001_0000_0100);
        send_cmd(OP_ABS, 64'h0000_0001_0000_0100);
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("abs_latency", n, 6);
        check("abs_err", err, 0);

        // REL
        timer_val = 64'h1000;
        push_seq(64'h1040);
        send_cmd(OP_REL, 64'h40);
        wait_idle();
        check("rel_err", err, 0);
        check("rel_periodic", periodic, 0);

        // PERIODIC with two reloads
        timer_val = 64'h100;
        push_seq(64'h120);
        send_cmd(OP_PERIODIC, 64'h20);
        wait_idle();
        check("per_periodic", periodic, 1);
        check("per_tick0", tick_cnt, 0);
        push_seq(64'h140);
        timer_val = 64'h120;
        wait_idle();
        check("per_tick1", tick_cnt, 1);
        push_seq(64'h160);
        timer_val = 64'h140;
        wait_idle();
        check("per_tick2", tick_cnt, 2);
        check("per_periodic2", periodic, 1);

        // Reload and command in the same cycle: reload first
        push_seq(64'h180);
        push_seq(64'h1000);
        timer_val = 64'h160;
        cmd_valid = 1'b1;
        cmd_op    = OP_ABS;
        cmd_data  = 64'h1000;
        #1;
        check("prio_cmd_ready", cmd_ready, 0);
        check("prio_busy", busy, 1);
        send_cmd(OP_ABS, 64'h1000);
        check("prio_tick_before_cmd", tick_cnt, 3);
        wait_idle();
        check("prio_periodic", periodic, 1);

        // STOP: no bus traffic
        send_cmd(OP_STOP, 64'h0);
        check("stop_periodic", periodic, 0);
        repeat (10) @(negedge clk);
        check("stop_busy", busy, 0);

        // Error on step1 of a periodic command
        timer_val = 64'h2000;
        er_at = wr_num + 2;
        exp_q.push_back('{addr: A_HI, data: 32'hFFFF_FFFF});
        exp_q.push_back('{addr: A_LO, data: 32'h0000_2020});
        send_cmd(OP_PERIODIC, 64'h20);
        wait_idle();
        er_at = -1;
        check("er_err", err, 1);
        check("er_periodic", periodic, 0);
        push_seq(64'h5000);
        send_cmd(OP_ABS, 64'h5000);
        check("er_clear_on_accept", err, 0);
        wait_idle();
        check("er_clear_after", err, 0);

        // Response timeout
        no_resp = 1'b1;
        exp_q.push_back('{addr: A_HI, data: 32'hFFFF_FFFF});
        send_cmd(OP_ABS, 64'h6000);
        check("tmo_ack_seen", tmr_req && tmr_req_ack, 1);
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            if (err) break;
            n++;
        end
        check("tmo_cycles", n, 15);
        check("tmo_err", err, 1);
        no_resp = 1'b0;
        wait_idle();

`ifdef SCR1_TIMER_SEQ_MISS_CNT_EN
        // Period 1 with mtime far ahead: each reload is already missed
        timer_val = 64'h100;
        push_seq(64'h101);
        push_seq(64'h102);
        push_seq(64'h103);
        send_cmd(OP_PERIODIC, 64'h1);
        check("miss_clear", miss_cnt, 0);
        timer_val = 64'h200;
        n = 0;
        while (tick_cnt != 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        timer_val = 64'h100;
        wait_idle();
        check("miss_tick", tick_cnt, 2);
        check("miss_cnt", miss_cnt, 2);
`endif

        // Reset during step1
        exp_q.push_back('{addr: A_HI, data: 32'hFFFF_FFFF});
        exp_q.push_back('{addr: A_LO, data: 32'h0000_7000});
        send_cmd(OP_ABS, 64'h7000);
        n = 0;
        while (!(tmr_req && tmr_addr == A_LO) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_step1_seen", tmr_req && (tmr_addr == A_LO), 1);
        #1 rst_n = 1'b0;
        #1;
        check("rstmid_tmr_req", tmr_req, 0);
        check("rstmid_cmd_ready", cmd_ready, 1);
        check("rstmid_tmr_addr", tmr_addr, 0);
        check("rstmid_tmr_wdata", tmr_wdata, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_err", err, 0);
        check("rstmid_periodic", periodic, 0);
        check("rstmid_tick_cnt", tick_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scr1_timer_seq.md
Name: scr1_timer_seq

Overview:
- Bus-master sequencer for the memory-mapped timer's dmem slave port.
- Accepts 64-bit compare commands: absolute, relative to the current mtime, or periodic auto-reload.
- Issues the glitch-free three-write mtimecmp update: HI=FFFFFFFF, then LO, then HI.
- Sits beside the timer, feeding its dmem port through the SoC dmem mux; frees the core from tick re-arming.

Parameters:
TMR_BASE, 32'hF004_0000, timer base address; MTIMECMPLO = base+0x10, MTIMECMPHI = base+0x14
RESP_TIMEOUT, 15, max cycles waiting for a non-NOTRDY response before error (range 1..255)

Ports:
clk  in  1  core clock
rst_n  in  1  async reset, active low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid & ready
cmd_op  in  2  00 ABS, 01 REL, 10 STOP, 11 PERIODIC
cmd_data  in  64  ABS: compare value; REL: delta; PERIODIC: period; STOP: ignored
timer_val  in  64  current mtime from timer
timer_irq  in  1  timer interrupt level
tmr_req  out  1  dmem request to timer
tmr_cmd  out  1  always SCR1_MEM_CMD_WR when tmr_req=1
tmr_width  out  type_scr1_mem_width_e  always SCR1_MEM_WIDTH_WORD
tmr_addr  out  `SCR1_DMEM_AWIDTH  target address
tmr_wdata  out  `SCR1_DMEM_DWIDTH  write data
tmr_req_ack  in  1  slave accepts request this cycle
tmr_resp  in  2  NOTRDY / RDY_OK / RDY_ER
busy  out  1  sequence in progress or reload pending
err  out  1  sticky error; cleared on next accepted command
periodic  out  1  periodic mode active
tick_cnt  out  32  completed periodic reloads, wraps at 2^32

Behaviour:
- Reset values: cmd_ready=1, tmr_req=0, tmr_addr=0, tmr_wdata=0, busy=0, err=0, periodic=0, tick_cnt=0.
- Internal registers cleared on reset: cmp_shadow[63:0], period[63:0], step[1:0], timeout counter.
- FSM states: IDLE, ISSUE, WAIT.
- cmd_ready = (state==IDLE) & ~reload_cond, where reload_cond = periodic & timer_irq.
- Accept in IDLE; target and mode update on the accept edge:
  - ABS: target=cmd_data; periodic unchanged.
  - REL: target=timer_val+cmd_data (64-bit, wraps); periodic unchanged.
  - PERIODIC: period=cmd_data; target=timer_val+cmd_data; periodic=1; tick_cnt=0.
  - STOP: periodic=0; no bus traffic; stay IDLE.
- Every non-STOP accept latches cmp_shadow=target, step=0 and goes to ISSUE.
- Reload: in IDLE with reload_cond=1:
  - cmp_shadow=cmp_shadow+period (wraps), step=0, go to ISSUE.
  - Reload has priority over cmd_valid in the same cycle.
- Step data:
  - step0: addr CMPHI, wdata FFFFFFFF.
  - step1: addr CMPLO, wdata cmp_shadow[31:0].
  - step2: addr CMPHI, wdata cmp_shadow[63:32].
- ISSUE: tmr_req=1 with stable addr/wdata.
  - Hold until tmr_req_ack=1, then go to WAIT; tmr_req=0 from the next cycle.
- WAIT: timeout counter loads 0 on entry and increments each cycle.
  - RDY_OK, step<2: step+1, go to ISSUE (one idle bus cycle between writes).
  - RDY_OK, step==2: go to IDLE; tick_cnt+1 if the sequence was a reload.
  - RDY_ER, or counter reaches RESP_TIMEOUT with resp NOTRDY: err=1, periodic=0, go to IDLE; cmp_shadow holds.
- Minimum latency, accept to IDLE with a 1-cycle-ack slave: 6 cycles.
- busy = (state!=IDLE) | reload_cond.
- timer_irq deasserts on the step0 write. Level sensing therefore cannot double-trigger once the sequence completes.
- If the new compare is already <= mtime, the timer reasserts irq; in periodic mode this triggers an immediate back-to-back reload (catch-up).
- Reset mid-sequence: tmr_req drops asynchronously and the FSM returns to IDLE.
  - The timer may be left with CMPHI=FFFFFFFF, i.e. no interrupt; this is acceptable by design.

Optional Feature:
SCR1_TIMER_SEQ_MISS_CNT_EN
- Defined: adds output miss_cnt[15:0], reset 0, cleared on PERIODIC accept.
  - Increments, saturating at FFFF, on each reload whose new cmp_shadow <= timer_val at the reload edge.
- Not defined: port and logic absent; behaviour otherwise identical.

Test Plan:
- ABS 0x0000_0001_0000_0100, ack=1, resp OK after 1 cycle:
  - bus sees writes (0x14,FFFFFFFF), (0x10,00000100), (0x14,00000001) in order.
  - cmd_ready returns 6 cycles after accept; err=0.
- REL delta=0x40 with timer_val=0x1000 at accept -> final writes LO=0x1040, HI=0.
- PERIODIC period=0x20 at timer_val=0x100, run to three irqs:
  - programmed compares 0x120, 0x140, 0x160; tick_cnt=2 after the second reload completes.
  - STOP afterwards -> periodic=0, no further writes.
- Step1 answered RDY_ER -> err=1, periodic=0, no step2 write; next accepted ABS clears err.
- Slave never responds (NOTRDY) -> err=1 exactly RESP_TIMEOUT=15 cycles after entering WAIT.
- cmd_valid and reload_cond in the same cycle -> reload runs first, cmd_ready=0 until done, then the command is accepted.
- rst_n pulsed during step1 -> tmr_req=0 immediately, all outputs at reset values.
- With SCR1_TIMER_SEQ_MISS_CNT_EN: period=1 with a slow slave -> miss_cnt increments on each missed reload.
